// File: rtl/avst_frame_irq_pkg.sv
// Shared register map, field positions and tracker state for the Avalon-ST frame monitor.
// The optional beat counters are controlled by FRAME_IRQ_BEATCNT_EN (see avst_pkt_tracker).
package avst_frame_irq_pkg;

  localparam logic [4:0] REG_CTRL           = 5'h00;
  localparam logic [4:0] REG_STATUS         = 5'h01;
  localparam logic [4:0] REG_FRAME_CNT_BASE = 5'h04;
  localparam logic [4:0] REG_BEAT_CNT_BASE  = 5'h0C;

  localparam int unsigned EOP_LSB = 0;
  localparam int unsigned SOP_LSB = 8;
  localparam int unsigned ERR_LSB = 16;
  localparam int unsigned GIE_BIT = 31;

  localparam logic [3:0] VIDEO_PKT_TYPE = 4'h0;

  typedef enum logic [0:0] {StIdle, StInPkt} trk_state_e;

  // Writable CTRL bits: one bit per implemented channel in each enable byte, plus GIE.
  function automatic logic [31:0] ctrl_mask(int unsigned num_ch);
    logic [7:0]  ch;
    logic [31:0] m;
    ch = 8'((32'd1 << num_ch) - 32'd1);
    m = '0;
    m[EOP_LSB +: 8] = ch;
    m[SOP_LSB +: 8] = ch;
    m[ERR_LSB +: 8] = ch;
    m[GIE_BIT]      = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/avst_pkt_tracker.sv
// Per-channel packet framing tracker: IDLE/IN_PKT FSM, video frame counter and event pulses.
// Beat counting of video packets is built only when FRAME_IRQ_BEATCNT_EN is defined.
module avst_pkt_tracker
  import avst_frame_irq_pkg::*;
#(
  parameter int unsigned CntW  = 16,
  parameter int unsigned BeatW = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             beat_i,
  input  logic             sop_i,
  input  logic             eop_i,
  input  logic [3:0]       pkt_type_i,
  input  logic             frame_clr_i,
  output logic             sop_evt_o,
  output logic             eop_evt_o,
  output logic             err_evt_o,
  output logic             sop_o,
  output logic             eop_o,
  output logic [CntW-1:0]  frame_cnt_o,
  output logic [BeatW-1:0] beat_cnt_o
);

  trk_state_e      state_q;
  logic            video_q;
  logic            sop_q;
  logic            eop_q;
  logic [CntW-1:0] frame_q;
  logic            pkt_done;
  logic            video_done;

  // A packet completes on EOP only if it was opened, either earlier or on this very beat.
  always_comb begin
    sop_evt_o  = beat_i & sop_i;
    eop_evt_o  = beat_i & eop_i;
    err_evt_o  = beat_i & ((state_q == StInPkt) ? sop_i : ~sop_i);
    pkt_done   = beat_i & eop_i & (sop_i | (state_q == StInPkt));
    video_done = pkt_done & (sop_i ? (pkt_type_i == VIDEO_PKT_TYPE) : video_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      video_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      sop_q <= sop_evt_o;
      eop_q <= eop_evt_o;
      if (frame_clr_i) begin
        frame_q <= video_done ? CntW'(1) : '0;
      end else if (video_done) begin
        frame_q <= frame_q + CntW'(1);
      end
      if (beat_i) begin
        if (sop_i) begin
          video_q <= (pkt_type_i == VIDEO_PKT_TYPE);
        end
        if (sop_i && !eop_i) begin
          state_q <= StInPkt;
        end else if (eop_i) begin
          state_q <= StIdle;
        end
      end
    end
  end

  assign sop_o       = sop_q;
  assign eop_o       = eop_q;
  assign frame_cnt_o = frame_q;

`ifdef FRAME_IRQ_BEATCNT_EN
  logic [BeatW-1:0] run_q;
  logic [BeatW-1:0] last_q;
  logic [BeatW-1:0] run_inc;

  assign run_inc = (run_q == {BeatW{1'b1}}) ? run_q : run_q + BeatW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q  <= '0;
      last_q <= '0;
    end else begin
      if (beat_i && sop_i) begin
        run_q <= BeatW'(1);
      end else if (beat_i && (state_q == StInPkt)) begin
        run_q <= run_inc;
      end
      if (video_done) begin
        last_q <= sop_i ? BeatW'(1) : run_inc;
      end
    end
  end

  assign beat_cnt_o = last_q;
`else
  assign beat_cnt_o = '0;
`endif

endmodule

// File: rtl/avst_frame_irq.sv
// Passive multi-channel Avalon-ST packet monitor with CSR slave and level interrupt.
// BEAT_CNT registers are live only when FRAME_IRQ_BEATCNT_EN is defined; otherwise they read 0.
module avst_frame_irq
  import avst_frame_irq_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned BEAT_W = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        st_valid,
  input  logic [NUM_CH-1:0]        st_ready,
  input  logic [NUM_CH-1:0]        st_sop,
  input  logic [NUM_CH-1:0]        st_eop,
  input  logic [NUM_CH*DATA_W-1:0] st_data,
  input  logic [4:0]               avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  output logic [31:0]              avs_readdata,
  output logic                     irq,
  output logic [NUM_CH-1:0]        sop_raw,
  output logic [NUM_CH-1:0]        eop_raw
);

  localparam logic [31:0] CtrlMask = ctrl_mask(NUM_CH);

  logic [NUM_CH-1:0] sop_evt;
  logic [NUM_CH-1:0] eop_evt;
  logic [NUM_CH-1:0] err_evt;
  logic [NUM_CH-1:0] frame_clr;
  logic [CNT_W-1:0]  frame_cnt [NUM_CH];
  logic [BEAT_W-1:0] beat_cnt  [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign frame_clr[c] = avs_write & (avs_address == REG_FRAME_CNT_BASE + 5'(c));

    avst_pkt_tracker #(
      .CntW  (CNT_W),
      .BeatW (BEAT_W)
    ) u_trk (
      .clk_i       (clk),
      .rst_ni      (reset_n),
      .beat_i      (st_valid[c] & st_ready[c]),
      .sop_i       (st_sop[c]),
      .eop_i       (st_eop[c]),
      .pkt_type_i  (st_data[c*DATA_W +: 4]),
      .frame_clr_i (frame_clr[c]),
      .sop_evt_o   (sop_evt[c]),
      .eop_evt_o   (eop_evt[c]),
      .err_evt_o   (err_evt[c]),
      .sop_o       (sop_raw[c]),
      .eop_o       (eop_raw[c]),
      .frame_cnt_o (frame_cnt[c]),
      .beat_cnt_o  (beat_cnt[c])
    );
  end

  // Payload bits and CTRL bits 30:24 carry nothing for this block.
  logic unused_in;
  assign unused_in = ^{avs_writedata[30:24], st_data};

  logic [31:0] ctrl_q, ctrl_d;
  logic [23:0] status_q, status_d;
  logic [23:0] status_set;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ctrl_we;
  logic        status_we;

  assign ctrl_we   = avs_write & (avs_address == REG_CTRL);
  assign status_we = avs_write & (avs_address == REG_STATUS);

  // Hardware set is applied after the W1C so a coincident event is never lost.
  always_comb begin
    status_set                    = '0;
    status_set[EOP_LSB +: NUM_CH] = eop_evt;
    status_set[SOP_LSB +: NUM_CH] = sop_evt;
    status_set[ERR_LSB +: NUM_CH] = err_evt;
    status_d = (status_q & ~(status_we ? avs_writedata[23:0] : 24'h0)) | status_set;
    ctrl_d   = ctrl_we ? (avs_writedata & CtrlMask) : ctrl_q;
    irq_d    = ctrl_q[GIE_BIT] & |(status_q & ctrl_q[23:0]);
  end

  always_comb begin
    rdata_d = '0;
    if (avs_address == REG_CTRL) begin
      rdata_d = ctrl_q;
    end else if (avs_address == REG_STATUS) begin
      rdata_d = {8'h00, status_q};
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (avs_address == REG_FRAME_CNT_BASE + 5'(c)) begin
        rdata_d = 32'(frame_cnt[c]);
      end
      if (avs_address == REG_BEAT_CNT_BASE + 5'(c)) begin
        rdata_d = 32'(beat_cnt[c]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      irq_q    <= irq_d;
      if (avs_read) begin
        rdata_q <= rdata_d;
      end
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_avst_frame_irq.sv
// Randomized + directed bench for avst_frame_irq against a behavioural packet model.
module tb_avst_frame_irq;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 24;
  localparam int CNT_W  = 4;
  localparam int BEAT_W = 5;
  localparam int BEAT_MAX = (1 << BEAT_W) - 1;
  localparam logic [31:0] CTRL_MASK_TB = 32'h8003_0303;
`ifdef FRAME_IRQ_BEATCNT_EN
  localparam bit BEAT_EN = 1'b1;
`else
  localparam bit BEAT_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [NUM_CH-1:0]        st_valid = '0;
  logic [NUM_CH-1:0]        st_ready = '0;
  logic [NUM_CH-1:0]        st_sop = '0;
  logic [NUM_CH-1:0]        st_eop = '0;
  logic [NUM_CH*DATA_W-1:0] st_data = '0;
  logic [4:0]               avs_address = '0;
  logic                     avs_read = 1'b0;
  logic                     avs_write = 1'b0;
  logic [31:0]              avs_writedata = '0;
  logic [31:0]              avs_readdata;
  logic                     irq;
  logic [NUM_CH-1:0]        sop_raw;
  logic [NUM_CH-1:0]        eop_raw;

  always #5 clk = ~clk;

  avst_frame_irq #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .BEAT_W (BEAT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_sop        (st_sop),
    .st_eop        (st_eop),
    .st_data       (st_data),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .sop_raw       (sop_raw),
    .eop_raw       (eop_raw)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Behavioural model: m_len is the length of the open packet, -1 when no packet is open.
  logic [31:0]       m_ctrl, m_status;
  int                m_frame [NUM_CH];
  int                m_last  [NUM_CH];
  int                m_len   [NUM_CH];
  bit                m_vid   [NUM_CH];
  logic [NUM_CH-1:0] e_sop, e_eop;
  logic              e_irq;
  logic [31:0]       e_rdata;

  function automatic logic [31:0] m_read(int a);
    if (a == 0) return m_ctrl;
    if (a == 1) return m_status;
    if (a >= 4 && a < 4 + NUM_CH) return 32'(m_frame[a-4]);
    if (a >= 12 && a < 12 + NUM_CH) return BEAT_EN ? 32'(m_last[a-12]) : 32'h0;
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_status = '0; e_sop = '0; e_eop = '0; e_irq = 1'b0; e_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_frame[c] = 0; m_last[c] = 0; m_len[c] = -1; m_vid[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [31:0] set;
    int a, len;
    bit b, s, e, done, vid;
    set = '0;
    a = int'(avs_address);
    if (avs_read) e_rdata = m_read(a);
    e_irq = m_ctrl[31] && ((m_status & m_ctrl & 32'h00FF_FFFF) != 0);
    for (int c = 0; c < NUM_CH; c++) begin
      b = st_valid[c] && st_ready[c]; s = st_sop[c]; e = st_eop[c];
      e_sop[c] = b && s; e_eop[c] = b && e;
      done = 1'b0; vid = 1'b0; len = 0;
      if (b) begin
        if (s) begin
          if (m_len[c] >= 0) set[16+c] = 1'b1;
          m_len[c] = 1;
          m_vid[c] = (st_data[c*DATA_W +: 4] == 4'h0);
        end else if (m_len[c] < 0) begin
          set[16+c] = 1'b1;
        end else begin
          m_len[c]++;
        end
        if (e && m_len[c] >= 0) begin
          done = 1'b1; vid = m_vid[c]; len = m_len[c]; m_len[c] = -1;
        end
        if (s) set[8+c] = 1'b1;
        if (e) set[c] = 1'b1;
      end
      if (avs_write && a == 4 + c) m_frame[c] = 0;
      if (done && vid) begin
        m_frame[c] = (m_frame[c] + 1) % (1 << CNT_W);
        m_last[c]  = (len > BEAT_MAX) ? BEAT_MAX : len;
      end
    end
    if (avs_write && a == 1) m_status = m_status & ~avs_writedata;
    m_status = m_status | set;
    if (avs_write && a == 0) m_ctrl = avs_writedata & CTRL_MASK_TB;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sop_raw", 32'(sop_raw), 32'(e_sop));
      check("eop_raw", 32'(eop_raw), 32'(e_eop));
      check("irq", 32'(irq), 32'(e_irq));
      check("readdata", avs_readdata, e_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    st_valid = '0; st_ready = '0; st_sop = '0; st_eop = '0;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic set_beat(int c, bit s, bit e, logic [31:0] d);
    st_valid[c] = 1'b1; st_ready[c] = 1'b1; st_sop[c] = s; st_eop[c] = e;
    st_data[c*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  task automatic send_beat(int c, bit s, bit e, logic [31:0] d);
    set_beat(c, s, e, d);
    tick();
    idle_all();
  endtask

  task automatic csr_write(logic [4:0] a, logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic csr_check(string name, logic [4:0] a, logic [31:0] exp);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    check(name, avs_readdata, exp);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    int r;
    repeat (3) tick();
    reset_n = 1'b1;
    chk_en  = 1'b1;
    tick();

    check("reset irq", 32'(irq), 32'h0);
    csr_check("reset ctrl", 5'h00, 32'h0);
    csr_check("reset status", 5'h01, 32'h0);

    // CTRL masking and unmapped reads
    csr_write(5'h00, 32'hFFFF_FFFF);
    csr_check("ctrl mask", 5'h00, 32'h8003_0303);
    csr_check("unmapped 0x02", 5'h02, 32'h0);
    csr_check("unmapped 0x06", 5'h06, 32'h0);
    csr_write(5'h00, 32'h8000_0001);

    // 10-beat video packet on channel 0
    send_beat(0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) send_beat(0, 1'b0, 1'b0, 32'h5A5A5);
    send_beat(0, 1'b0, 1'b1, 32'h0);
    check("eop pulse", 32'(eop_raw), 32'h1);
    check("irq N+1", 32'(irq), 32'h0);
    tick();
    check("eop pulse gone", 32'(eop_raw), 32'h0);
    check("irq N+2", 32'(irq), 32'h1);
    csr_check("status after video", 5'h01, 32'h0000_0101);
    csr_check("frame0 = 1", 5'h04, 32'h1);
    csr_check("beat0 = 10", 5'h0C, BEAT_EN ? 32'd10 : 32'd0);
    csr_write(5'h01, 32'h00FF_FFFF);

    // 3-beat control packet on channel 1
    send_beat(1, 1'b1, 1'b0, 32'hF);
    send_beat(1, 1'b0, 1'b0, 32'h0);
    send_beat(1, 1'b0, 1'b1, 32'h0);
    csr_check("status ctrl pkt", 5'h01, 32'h0000_0202);
    csr_check("frame1 stays 0", 5'h05, 32'h0);
    csr_write(5'h01, 32'h00FF_FFFF);

    // Missing EOP on channel 0
    csr_write(5'h00, 32'h8001_0001);
    send_beat(0, 1'b1, 1'b0, 32'h0);
    send_beat(0, 1'b1, 1'b0, 32'h0);
    tick();
    check("irq on err", 32'(irq), 32'h1);
    csr_check("status err", 5'h01, 32'h0001_0100);
    csr_write(5'h01, 32'h0001_0000);
    tick();
    check("irq after w1c", 32'(irq), 32'h0);
    csr_check("status err cleared", 5'h01, 32'h0000_0100);
    send_beat(0, 1'b0, 1'b1, 32'h0);
    csr_check("frame0 after restart", 5'h04, 32'h2);
    csr_check("beat0 after restart", 5'h0C, BEAT_EN ? 32'd2 : 32'd0);
    csr_write(5'h01, 32'h00FF_FFFF);

    // Single-beat packet, then W1C racing an EOP set
    send_beat(0, 1'b1, 1'b1, 32'h0);
    csr_check("status single", 5'h01, 32'h0000_0101);
    csr_check("beat0 single", 5'h0C, BEAT_EN ? 32'd1 : 32'd0);
    set_beat(0, 1'b1, 1'b1, 32'h0);
    csr_write(5'h01, 32'h0000_0001);
    idle_all();
    csr_check("set wins over w1c", 5'h01, 32'h0000_0101);
    csr_check("frame0 = 4", 5'h04, 32'h4);

    // Frame counter wrap and clear-vs-increment
    csr_write(5'h04, 32'h0);
    for (int i = 0; i < 16; i++) send_beat(0, 1'b1, 1'b1, 32'h0);
    csr_check("frame0 wraps", 5'h04, 32'h0);
    set_beat(0, 1'b1, 1'b1, 32'h0);
    csr_write(5'h04, 32'h0);
    idle_all();
    csr_check("clear + inc = 1", 5'h04, 32'h1);

    // Reset mid-packet
    send_beat(0, 1'b1, 1'b0, 32'h0);
    pulse_reset();
    csr_check("ctrl after reset", 5'h00, 32'h0);
    csr_check("status after reset", 5'h01, 32'h0);
    csr_check("frame0 after reset", 5'h04, 32'h0);
    csr_write(5'h00, 32'h8001_0000);
    send_beat(0, 1'b0, 1'b1, 32'h0);
    tick();
    check("irq orphan eop", 32'(irq), 32'h1);
    csr_check("status orphan eop", 5'h01, 32'h0001_0001);
    csr_check("beat0 after reset", 5'h0C, 32'h0);
    csr_check("frame0 no inc", 5'h04, 32'h0);

    // Randomized traffic checked cycle-by-cycle against the model
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_valid[c] = ($urandom_range(0, 3) != 0);
        st_ready[c] = ($urandom_range(0, 3) != 0);
        st_sop[c]   = ($urandom_range(0, 39) == 0);
        st_eop[c]   = ($urandom_range(0, 29) == 0);
        d = $urandom;
        if ($urandom_range(0, 1) == 1) d[3:0] = 4'h0;
        st_data[c*DATA_W +: DATA_W] = DATA_W'(d);
      end
      avs_read = 1'b0;
      avs_write = 1'b0;
      r = $urandom_range(0, 15);
      if (r < 4) begin
        avs_read = 1'b1;
        avs_address = 5'($urandom_range(0, 19));
      end else if (r == 4) begin
        avs_write = 1'b1; avs_address = 5'h00; avs_writedata = $urandom;
      end else if (r == 5) begin
        avs_write = 1'b1; avs_address = 5'h01; avs_writedata = $urandom;
      end else if (r == 6) begin
        avs_write = 1'b1; avs_address = 5'(4 + $urandom_range(0, NUM_CH - 1));
        avs_writedata = $urandom;
      end
      if (i == 2000) pulse_reset();
      tick();
    end
    idle_all();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
